// File: rtl/noc_ni_tx.sv
// noc_ni_tx: network-interface transmitter.
// Core requests are queued in a small FIFO, packed into 20-bit flits
// {dst_cluster, dst_local, payload} and sent to one router input port under
// credit-based flow control. There is one credit per router input-buffer slot,
// and one credit comes back per ci pulse.
// Optional build macro: NI_TX_STATS_EN enables the stat_flits / stat_stall
// counters. When the macro is undefined, both outputs are tied to zero.
`timescale 1ns/1ps

module noc_ni_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   core_data,
    input  logic [3:0]    core_dst,
    input  logic          core_valid,
    output logic          core_ready,
    input  logic          tx_en,
    output logic [19:0]   o,
    output logic          vo,
    input  logic          ci,
    output logic [CW-1:0] cred_cnt,
    output logic          err_credit,
    output logic [15:0]   stat_flits,
    output logic [15:0]   stat_stall
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [19:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          wr_s;
    logic          launch_s;
    logic [CW-1:0] cred_next_s;
    logic          err_set_s;

    // A write is accepted against the registered ready, so a full FIFO never
    // writes through, even when a launch frees a slot on the same edge.
    assign wr_s     = core_valid & core_ready;
    assign launch_s = (count_r != '0) & (cred_cnt != '0) & tx_en;

    // Next FIFO occupancy from the write/launch pair.
    always_comb begin
        count_next_s = count_r;
        case ({wr_s, launch_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Next credit count. A returned credit with no launch while already at
    // CREDITS is a protocol error: saturate and flag it.
    always_comb begin
        cred_next_s = cred_cnt;
        err_set_s   = 1'b0;
        case ({launch_s, ci})
            2'b10:   cred_next_s = cred_cnt - CW'(1);
            2'b01: begin
                if (cred_cnt == CRED_MAX) begin
                    err_set_s = 1'b1;
                end else begin
                    cred_next_s = cred_cnt + CW'(1);
                end
            end
            default: cred_next_s = cred_cnt;
        endcase
    end

    // FIFO storage. Content is cleared on reset so that no stale data survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 20'h0_0000;
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= {core_dst, core_data};
        end
    end

    // FIFO pointers, which wrap naturally at the power-of-two depth, plus the
    // occupancy count and registered ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            core_ready <= 1'b1;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (launch_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            core_ready <= (count_next_s != FULL_CNT);
        end
    end

    // Flit output: vo pulses for one cycle per launch, and o holds between flits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o  <= 20'h0_0000;
            vo <= 1'b0;
        end else if (launch_s) begin
            o  <= mem_r[rd_ptr_r];
            vo <= 1'b1;
        end else begin
            vo <= 1'b0;
        end
    end

    // Credit counter and the sticky credit-overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cred_cnt   <= CRED_MAX;
            err_credit <= 1'b0;
        end else begin
            cred_cnt   <= cred_next_s;
            err_credit <= err_credit | err_set_s;
        end
    end

`ifdef NI_TX_STATS_EN
    // Statistics: launched flits, and cycles blocked only by a lack of credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_flits <= 16'h0000;
            stat_stall <= 16'h0000;
        end else begin
            if (launch_s) begin
                stat_flits <= stat_flits + 16'd1;
            end
            if ((count_r != '0) && tx_en && (cred_cnt == '0)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`else
    assign stat_flits = 16'h0000;
    assign stat_stall = 16'h0000;
`endif

endmodule
